// File: rtl/eth_frame_encapsulator.sv
// eth_frame_encapsulator: buffers a payload and emits preamble, SFD, header, length, payload, pad, FCS and IFG.
module eth_frame_encapsulator #(
  parameter logic [47:0] DEST_MAC = 48'h023528fbdd66,
  parameter logic [47:0] SRC_MAC  = 48'h023528fbdd66,
  parameter int          WIDTH    = 8,
  parameter int          SIZE     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             buffer_ready,
  input  logic             eth_tx_en,
  output logic             full,
  output logic             busy,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_en,
  output logic             frame_done
);
  localparam int AW = $clog2(SIZE);
  typedef enum logic [3:0] {IDLE, PRE, SFD, DEST, SRC, LEN, PAY, PAD, FCS, IFG} state_t;
  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d, nxt, count_q, len_q;
  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem [SIZE];
  logic             busy_q, push, pop;
  logic [31:0]      crc_q;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  assign full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign busy       = busy_q;
  assign push       = wr_en && !busy_q && !full;
  assign pop        = state_q == PAY;
  assign nxt        = cnt_q + 16'd1;
  assign tx_en      = !(state_q == IDLE || state_q == IFG);
  assign frame_done = state_q == IFG && cnt_q == 16'd11;

  // Asynchronous read keeps the head byte ready, so payload bytes stream back-to-back.
  always_comb begin
    tx_data = state_q == PRE  ? 8'h55 :
              state_q == SFD  ? 8'hD5 :
              state_q == DEST ? 8'(DEST_MAC >> {3'd5 - cnt_q[2:0], 3'b000}) :
              state_q == SRC  ? 8'(SRC_MAC >> {3'd5 - cnt_q[2:0], 3'b000}) :
              state_q == LEN  ? (cnt_q[0] ? len_q[7:0] : len_q[15:8]) :
              state_q == PAY  ? mem[rd_q[AW-1:0]] :
              state_q == FCS  ? 8'(~crc_q >> {cnt_q[1:0], 3'b000}) : 8'h00;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = nxt;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (busy_q && eth_tx_en) state_d = PRE;
      end
      PRE:  if (cnt_q == 16'd6) begin state_d = SFD; cnt_d = '0; end
      SFD:  begin state_d = DEST; cnt_d = '0; end
      DEST: if (cnt_q == 16'd5) begin state_d = SRC; cnt_d = '0; end
      SRC:  if (cnt_q == 16'd5) begin state_d = LEN; cnt_d = '0; end
      LEN:  if (cnt_q == 16'd1) begin state_d = len_q == 16'd0 ? PAD : PAY; cnt_d = '0; end
      // cnt keeps counting data bytes through PAD so payload+pad totals 46
      PAY:  if (nxt == len_q) begin
        state_d = nxt >= 16'd46 ? FCS : PAD;
        cnt_d   = nxt >= 16'd46 ? 16'd0 : nxt;
      end
      PAD:  if (nxt >= 16'd46) begin state_d = FCS; cnt_d = '0; end
      FCS:  if (cnt_q == 16'd3) begin state_d = IFG; cnt_d = '0; end
      IFG:  if (cnt_q == 16'd11) begin state_d = IDLE; cnt_d = '0; end
      default: begin state_d = IDLE; cnt_d = '0; end
    endcase
  end

  always_ff @(posedge clk) if (push) mem[wr_q[AW-1:0]] <= data_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      crc_q   <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push) begin
        wr_q    <= wr_q + {{AW{1'b0}}, 1'b1};
        count_q <= count_q + 16'd1;
      end
      if (pop) rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
      if (buffer_ready && !busy_q) begin
        busy_q <= 1'b1;
        len_q  <= push ? count_q + 16'd1 : count_q;
      end
      if (frame_done) begin
        busy_q  <= 1'b0;
        count_q <= '0;
      end
      crc_q <= state_q == IDLE ? '1 :
               (state_q >= DEST && state_q <= PAD) ? crc_next(crc_q, tx_data) : crc_q;
    end
  end
endmodule

// File: tb/tb_eth_frame_encapsulator.sv
// tb_eth_frame_encapsulator: frame-level model with per-cycle output comparison.
module tb_eth_frame_encapsulator;
  localparam int SIZE = 64;
  logic clk = 0, rst = 1, wr_en = 0, buffer_ready = 0, eth_tx_en = 0;
  logic [7:0] data_in = 0;
  logic full, busy, tx_en, frame_done;
  logic [7:0] tx_data;
  int errors = 0, checks = 0;
  logic [9:0] stream[$];
  logic [7:0] q[$], pay[$], cap[$];
  bit mbusy = 0, started = 0;

  eth_frame_encapsulator #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .buffer_ready(buffer_ready),
    .eth_tx_en(eth_tx_en), .full(full), .busy(busy), .tx_data(tx_data), .tx_en(tx_en),
    .frame_done(frame_done));

  always #5 clk = ~clk;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r = c;
    for (int i = 0; i < 8; i++) begin
      r = ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0) ^ (r >> 1);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void build();
    logic [7:0] f[$];
    logic [47:0] mac = 48'h023528fbdd66;
    logic [15:0] n = 16'(pay.size());
    logic [31:0] c = '1;
    repeat (7) f.push_back(8'h55);
    f.push_back(8'hD5);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 6; i++) f.push_back(mac[47-8*i -: 8]);
    f.push_back(n[15:8]);
    f.push_back(n[7:0]);
    foreach (pay[i]) f.push_back(pay[i]);
    while (f.size() < 22 + 46) f.push_back(8'h00);
    for (int i = 8; i < f.size(); i++) c = crc_upd(c, f[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    foreach (f[i]) stream.push_back({2'b01, f[i]});
    repeat (11) stream.push_back(10'h000);
    stream.push_back(10'h200);
  endfunction

  always @(posedge clk) if (!rst) begin
    if (started && stream.size() == 0) begin
      mbusy = 0;
      started = 0;
    end else if (!mbusy) begin
      if (wr_en && q.size() < SIZE) q.push_back(data_in);
      if (buffer_ready) begin
        mbusy = 1;
        pay = q;
      end
    end else if (!started && eth_tx_en) begin
      build();
      started = 1;
      q.delete();
    end
  end

  always @(negedge clk) if (!rst) begin
    logic [9:0] e;
    e = stream.size() != 0 ? stream.pop_front() : 10'h000;
    check("tx_en", tx_en, e[8]);
    check("tx_data", tx_data, e[7:0]);
    check("frame_done", frame_done, e[9]);
    check("busy", busy, mbusy);
    if (!mbusy) check("full", full, q.size() == SIZE);
    if (tx_en) cap.push_back(tx_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en = 1;
    data_in = b;
    tick();
    wr_en = 0;
  endtask

  task automatic ready();
    buffer_ready = 1;
    tick();
    buffer_ready = 0;
  endtask

  task automatic send(input int exp_len, input logic [7:0] lenlo);
    int n = 0;
    logic [31:0] c = '1;
    cap.delete();
    eth_tx_en = 1;
    tick();
    eth_tx_en = 0;
    while ((started || stream.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check("timeout", 1, 0);
    tick();
    check("frame_len", cap.size(), exp_len);
    if (cap.size() > 22) check("len_lo", cap[21], lenlo);
    for (int i = 8; i < cap.size(); i++) c = crc_upd(c, cap[i]);
    check("residue", c, 32'hDEBB20E3);
  endtask

  initial begin
    string s = "123456789";
    logic [31:0] c = '1;
    for (int i = 0; i < 9; i++) c = crc_upd(c, s[i]);
    check("crc_ref", ~c, 32'hCBF43926);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (2) tick();
    eth_tx_en = 1;
    tick();
    eth_tx_en = 0;
    repeat (5) tick();

    for (int i = 1; i <= 46; i++) wr(8'(i));
    ready();
    send(72, 8'h2E);
    if (cap.size() == 72) begin
      check("hdr_dest0", cap[8], 8'h02);
      check("pay0", cap[22], 8'h01);
      check("pay45", cap[67], 8'h2E);
    end

    wr(8'hAA); wr(8'hBB); wr(8'hCC); wr(8'hDD);
    ready();
    send(72, 8'h04);
    if (cap.size() == 72) begin
      check("pay3", cap[25], 8'hDD);
      check("pad0", cap[26], 8'h00);
    end

    ready();
    send(72, 8'h00);

    for (int i = 0; i < SIZE + 3; i++) wr(8'(i + 8'h80));
    ready();
    wr(8'h11); wr(8'h22);
    ready();
    send(26 + SIZE, 8'(SIZE));

    for (int i = 0; i < 50; i++) wr(8'(i * 3));
    ready();
    send(76, 8'd50);

    for (int i = 0; i < 46; i++) wr(8'(i));
    ready();
    eth_tx_en = 1;
    tick();
    eth_tx_en = 0;
    repeat (30) tick();
    rst = 1;
    stream.delete();
    q.delete();
    mbusy = 0;
    started = 0;
    #1 check("tx_en_async", tx_en, 0);
    repeat (2) tick();
    rst = 0;
    tick();
    check("busy_after_rst", busy, 0);
    wr(8'h10); wr(8'h20); wr(8'h30); wr(8'h40);
    ready();
    send(72, 8'h04);
    if (cap.size() == 72) check("rst_pay0", cap[22], 8'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
